// File: rtl/setup_deser.sv
// -----------------------------------------------------------------------------
// setup_deser
//   Serial configuration receiver for the FP adder setup path. Deserialises
//   MSB-first framed bitstreams, extracts one field from each complete frame
//   and commits it atomically to a shadowed parallel output. Framing errors
//   (short frame, overrun past the end of a frame) raise a sticky error flag.
//
// Parameters
//   FRAME_LEN  bits per frame (>= 2)
//   FIELD_LSB  frame-word bit index of the field LSB (first received bit is
//              frame-word bit FRAME_LEN-1)
//   FIELD_W    field width; FIELD_LSB + FIELD_W must not exceed FRAME_LEN
//   RST_VAL    reset/default value of parallel_out
//
// Ports
//   clk_in        in   1        clock, rising edge
//   rst_n_in      in   1        asynchronous active-low reset
//   serial_in     in   1        serial data, sampled when en_in=1
//   en_in         in   1        bit-valid qualifier
//   sof_in        in   1        start of frame, qualified by en_in
//   parallel_out  out  FIELD_W  committed field, changes only on commit
//   done_out      out  1        one-cycle pulse in the cycle after a commit
//   busy_out      out  1        high while a frame is being shifted in
//   err_out       out  1        sticky framing error, cleared by accepted sof
// -----------------------------------------------------------------------------
module setup_deser #(
  parameter int               FRAME_LEN = 32,
  parameter int               FIELD_LSB = 0,
  parameter int               FIELD_W   = 8,
  parameter logic [FIELD_W-1:0] RST_VAL = '0
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               serial_in,
  input  logic               en_in,
  input  logic               sof_in,
  output logic [FIELD_W-1:0] parallel_out,
  output logic               done_out,
  output logic               busy_out,
  output logic               err_out
);

  // Parameter sanity: reject impossible geometries at elaboration.
  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("setup_deser: FRAME_LEN must be at least 2");
  end
  if (FIELD_W < 1 || FIELD_LSB < 0 || FIELD_LSB + FIELD_W > FRAME_LEN) begin : g_bad_field
    $error("setup_deser: field does not fit inside the frame");
  end

  localparam int CNT_W = $clog2(FRAME_LEN);
  // Only FRAME_LEN-1 history bits are kept: the final bit of a frame is taken
  // straight from serial_in on the commit edge.
  localparam int SR_W  = FRAME_LEN - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SR_W-1:0]    sr_q;
  logic [FIELD_W-1:0] par_q;
  logic               done_q;
  logic               busy_q;
  logic               err_q;

  // Frame word as it would look with the current serial bit shifted in.
  logic [FRAME_LEN-1:0] word_d;
  logic [SR_W-1:0]      sr_d;
  logic [SR_W-1:0]      sr_start_d;
  logic [FIELD_W-1:0]   field_d;

  assign word_d     = {sr_q, serial_in};
  assign sr_d       = word_d[SR_W-1:0];
  assign sr_start_d = SR_W'(serial_in);
  // Shift-then-truncate selects word_d[FIELD_LSB +: FIELD_W].
  assign field_d    = FIELD_W'(word_d >> FIELD_LSB);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      par_q   <= RST_VAL;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (en_in) begin
        case (state_q)
          IDLE: begin
            // Bits without a start of frame are ignored while idle.
            if (sof_in) begin
              sr_q    <= sr_start_d;
              cnt_q   <= ONE_CNT;
              err_q   <= 1'b0;
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
          SHIFT: begin
            if (sof_in) begin
              // Short frame: flag it and restart with this bit as bit 0.
              sr_q  <= sr_start_d;
              cnt_q <= ONE_CNT;
              err_q <= 1'b1;
            end else if (cnt_q == LAST_CNT) begin
              // Final bit: commit on this very edge.
              sr_q    <= sr_d;
              cnt_q   <= '0;
              par_q   <= field_d;
              done_q  <= 1'b1;
              state_q <= HOLD;
              busy_q  <= 1'b0;
            end else begin
              sr_q  <= sr_d;
              cnt_q <= cnt_q + ONE_CNT;
            end
          end
          HOLD: begin
            if (sof_in) begin
              // Back-to-back frame, no dead cycle required.
              sr_q    <= sr_start_d;
              cnt_q   <= ONE_CNT;
              err_q   <= 1'b0;
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end else begin
              // Overrun: extra bit after a complete frame is discarded.
              err_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (state_q == HOLD) begin
        // A gap after the final bit closes the frame cleanly.
        state_q <= IDLE;
      end
    end
  end

  assign parallel_out = par_q;
  assign done_out     = done_q;
  assign busy_out     = busy_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_setup_deser.sv
// -----------------------------------------------------------------------------
// tb_setup_deser
//   Two receivers share clock and reset: d=0 uses the default geometry
//   (32-bit frame, field [7:0]); d=1 uses a 16-bit frame with field [9:4].
//   A reference model tracks each frame at the level of "bits collected so
//   far" and pushes every expected committed field into a queue; a monitor
//   pops the queue whenever done_out pulses and also checks busy/err/done.
// -----------------------------------------------------------------------------
module tb_setup_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] en  = '0;
  logic [1:0] sof = '0;
  logic [1:0] ser = '0;

  logic [7:0] par0;
  logic [5:0] par1;
  logic [1:0] done, busy, err;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  setup_deser u_dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .serial_in(ser[0]), .en_in(en[0]), .sof_in(sof[0]),
    .parallel_out(par0), .done_out(done[0]), .busy_out(busy[0]), .err_out(err[0])
  );

  setup_deser #(.FRAME_LEN(16), .FIELD_LSB(4), .FIELD_W(6), .RST_VAL(6'd0)) u_dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .serial_in(ser[1]), .en_in(en[1]), .sof_in(sof[1]),
    .parallel_out(par1), .done_out(done[1]), .busy_out(busy[1]), .err_out(err[1])
  );

  // ---------------- reference model ----------------
  int          got  [2];  // bits of the current frame received (0 = not in a frame)
  bit          after[2];  // a frame just completed and en has not dropped since
  logic [31:0] word [2];
  logic [7:0]  m_par[2];
  bit          m_err[2];
  bit          m_done[2];
  logic [7:0]  expq0[$];
  logic [7:0]  expq1[$];

  function automatic int flen(input int d); return (d != 0) ? 16 : 32; endfunction
  function automatic int flsb(input int d); return (d != 0) ? 4 : 0;   endfunction
  function automatic int fwid(input int d); return (d != 0) ? 6 : 8;   endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      got[d] = 0; after[d] = 1'b0; word[d] = '0;
      m_par[d] = '0; m_err[d] = 1'b0; m_done[d] = 1'b0;
    end
    expq0.delete();
    expq1.delete();
  endtask

  task automatic model_step(input int d);
    logic [31:0] f;
    m_done[d] = 1'b0;
    if (en[d]) begin
      if (sof[d]) begin
        m_err[d] = (got[d] > 0);          // sof inside a frame = short frame
        got[d]   = 1;
        word[d]  = {31'd0, ser[d]};
        after[d] = 1'b0;
      end else if (got[d] > 0) begin
        word[d] = {word[d][30:0], ser[d]};
        got[d]  = got[d] + 1;
        if (got[d] == flen(d)) begin
          f = (word[d] >> flsb(d)) & ((32'd1 << fwid(d)) - 32'd1);
          m_par[d]  = f[7:0];
          m_done[d] = 1'b1;
          if (d == 0) expq0.push_back(f[7:0]); else expq1.push_back(f[7:0]);
          got[d]   = 0;
          after[d] = 1'b1;
        end
      end else if (after[d]) begin
        m_err[d] = 1'b1;                  // overrun
      end
    end else begin
      after[d] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_par(input int d);
    return (d != 0) ? {2'b00, par1} : par0;
  endfunction

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_on) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(got[d] > 0));
          chk($sformatf("err%0d", d),  32'(err[d]),  32'(m_err[d]));
          chk($sformatf("done%0d", d), 32'(done[d]), 32'(m_done[d]));
          chk($sformatf("par%0d", d),  32'(get_par(d)), 32'(m_par[d]));
          if (done[d]) begin
            if ((d == 0 ? expq0.size() : expq1.size()) == 0) begin
              chk($sformatf("unexpected_commit%0d", d), 32'(get_par(d)), 32'hDEAD);
            end else begin
              e = (d == 0) ? expq0.pop_front() : expq1.pop_front();
              chk($sformatf("commit%0d", d), 32'(get_par(d)), 32'(e));
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int d, input bit e, input bit s, input bit b);
    @(negedge clk);
    en = '0; sof = '0;
    en[d] = e; sof[d] = s; ser[d] = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = '0; sof = '0;
    end
  endtask

  // Sends nb bits MSB first (sof on the first); bits past the frame length are
  // random. Inserts gl idle cycles after bit indices ga and gb.
  task automatic frame(input int d, input logic [31:0] w, input int nb,
                       input int ga, input int gb, input int gl);
    int  L;
    bit  b;
    L = flen(d);
    for (int i = 0; i < nb; i++) begin
      b = (i < L) ? w[L-1-i] : 1'($urandom_range(0, 1));
      drive(d, 1'b1, i == 0, b);
      if (i == ga || i == gb) idle(gl);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, nb, L;
    // Reset state
    #12;
    chk("rst_par0", 32'(par0), 32'h0);
    chk("rst_par1", 32'(par1), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err",  32'(err),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    idle(2);

    // 1: contiguous frame
    frame(0, 32'h0000_00A5, 32, -1, -1, 0);
    idle(2);
    chk("t1_par", 32'(par0), 32'hA5);
    chk("t1_err", 32'(err[0]), 32'h0);

    // 2: same frame with gaps after bits 5 and 20
    frame(0, 32'h0000_005A, 32, -1, -1, 0);
    idle(1);
    frame(0, 32'h0000_00A5, 32, 5, 20, 3);
    idle(2);
    chk("t2_par", 32'(par0), 32'hA5);

    // 3: good frame, short frame at bit 10 of the next, restarted frame
    frame(0, 32'h1234_5678, 32, -1, -1, 0);
    idle(1);
    frame(0, 32'hFFFF_FF3C, 10, -1, -1, 0);
    drive(0, 1'b1, 1'b1, 1'b1);            // sof at bit 10 -> restart
    idle(1);
    chk("t3_err_short", 32'(err[0]), 32'h1);
    chk("t3_par_held", 32'(par0), 32'h78);
    frame(0, 32'hFFFF_FF3C, 32, -1, -1, 0);
    idle(2);
    chk("t3_par_restart", 32'(par0), 32'h3C);

    // 4: overrun with 33 contiguous bits
    frame(0, 32'h0000_00C3, 33, -1, -1, 0);
    idle(2);
    chk("t4_err", 32'(err[0]), 32'h1);
    chk("t4_par", 32'(par0), 32'hC3);

    // 5: asynchronous reset mid-frame (after bit 17 is sampled)
    frame(0, 32'h0000_0011, 18, -1, -1, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en = '0; sof = '0;
    #1;
    chk("t5_par",  32'(par0), 32'h0);
    chk("t5_busy", 32'(busy[0]), 32'h0);
    chk("t5_err",  32'(err[0]), 32'h0);
    chk("t5_done", 32'(done[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    frame(0, 32'h0000_0066, 32, -1, -1, 0);
    idle(2);
    chk("t5_recover", 32'(par0), 32'h66);

    // 6: 16-bit geometry, back-to-back frames
    frame(1, 32'h0000_ABCD, 16, -1, -1, 0);
    frame(1, 32'h0000_5A50, 16, -1, -1, 0);
    idle(2);
    chk("t6_par_last", 32'(par1), 32'h25);
    chk("t6_err", 32'(err[1]), 32'h0);

    // Randomised frames: gaps, short frames, overruns, back-to-back
    for (int k = 0; k < 60; k++) begin
      d = $urandom_range(0, 1);
      L = flen(d);
      case ($urandom_range(0, 5))
        0:       nb = $urandom_range(1, L - 1);
        1:       nb = L + $urandom_range(1, 2);
        default: nb = L;
      endcase
      frame(d, $urandom, nb, $urandom_range(0, L - 1), $urandom_range(0, L - 1),
            $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end
    idle(4);
    chk("q0_drained", 32'(expq0.size()), 32'h0);
    chk("q1_drained", 32'(expq1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
